// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh router scheduler.
//   PCKG_SZ_DFLT : default packet width in bits
//   ID_W         : width of the routed output-terminal id (top byte of a packet)
//   dest_of()    : extracts the routed id from a default-width packet
//   sched_state_t: scheduler FSM encoding
package mesh_pkg;

   localparam int PCKG_SZ_DFLT = 40;
   localparam int ID_W         = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      PUSH  = 2'd2,
      POP   = 2'd3
   } sched_state_t;

   function automatic logic [ID_W-1:0] dest_of(input logic [PCKG_SZ_DFLT-1:0] pkt);
      return pkt[PCKG_SZ_DFLT-1 -: ID_W];
   endfunction

endpackage

// File: rtl/router_sched_rr_pick.sv
// Rotating-priority picker for four requesters.
//   req : request vector, one bit per terminal
//   ptr : index with the highest priority this cycle
//   hit : at least one request is set
//   idx : first set request at or after ptr, wrapping 3 -> 0
module rr_pick (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic       hit,
   output logic [1:0] idx
);

   logic [1:0] cand;

   always_comb begin
      hit  = 1'b0;
      idx  = ptr;
      cand = ptr;
      for (int i = 0; i < 4; i++) begin
         cand = ptr + 2'(i);
         if (!hit && req[cand]) begin
            hit = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/router_sched.sv
// Round-robin scheduler for the internal transfer path of one mesh router.
// Grants one terminal at a time, checks the routed destination, pushes the
// packet into the destination output FIFO and pops it from the source.
//   clk, rst   : clock, asynchronous active-low reset
//   pndng_i    : per-terminal head-packet-valid
//   data_out_i : per-terminal head packet, routed id in the top byte
//   full_o     : per-terminal output FIFO full
//   trn        : granted source terminal
//   push_i     : one-cycle write strobe for data_in_i into FIFO dest
//   data_in_i  : latched packet under transfer
//   pop_i      : one-cycle pop strobe for the head of terminal trn
//   busy       : scheduler not idle
//   drop_cnt   : saturating count of invalid-destination drops
//   tmo_cnt    : saturating count of blocked-head timeouts
//
// state | meaning
// IDLE  | searching pndng_i from rr_ptr for the next source
// CHECK | source latched; validate dest, wait on a full destination
// PUSH  | push_i strobe into the destination output FIFO
// POP   | pop_i strobe on the source, advance rr_ptr past it
module router_sched
   import mesh_pkg::*;
#(
   parameter int PCKG_SZ     = PCKG_SZ_DFLT,
   parameter int N_TERM      = 4,
   parameter int BLK_TIMEOUT = 15
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_TERM-1:0]              pndng_i,
   input  logic [N_TERM-1:0][PCKG_SZ-1:0] data_out_i,
   input  logic [N_TERM-1:0]              full_o,
   output logic [1:0]                     trn,
   output logic                           push_i,
   output logic [PCKG_SZ-1:0]             data_in_i,
   output logic                           pop_i,
   output logic                           busy,
   output logic [15:0]                    drop_cnt,
   output logic [15:0]                    tmo_cnt
);

   localparam int                WAIT_W   = $clog2(BLK_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(BLK_TIMEOUT - 1);
   localparam logic [15:0]       CNT_MAX  = 16'hFFFF;

   sched_state_t      state_q, state_d;
   logic [1:0]        rr_ptr;
   logic [WAIT_W-1:0] wait_cnt;
   logic              pick_hit;
   logic [1:0]        pick_idx;
   logic [ID_W-1:0]   dest;

   logic load, drop_inc, tmo_inc, wait_inc, wait_clr, ptr_adv;

   assign dest = data_in_i[PCKG_SZ-1 -: ID_W];

   rr_pick u_rr_pick (
      .req (pndng_i),
      .ptr (rr_ptr),
      .hit (pick_hit),
      .idx (pick_idx)
   );

   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      drop_inc = 1'b0;
      tmo_inc  = 1'b0;
      wait_inc = 1'b0;
      wait_clr = 1'b0;
      ptr_adv  = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_hit) begin
               load    = 1'b1;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (!pndng_i[trn]) begin
               // source withdrew; rr_ptr is left alone so it is retried first
               state_d  = IDLE;
               wait_clr = 1'b1;
            end else if (dest >= ID_W'(N_TERM)) begin
               state_d  = POP;
               drop_inc = 1'b1;
               wait_clr = 1'b1;
            end else if (full_o[dest[1:0]]) begin
               if (wait_cnt == WAIT_END) begin
                  // abandon without popping; the head stays at the source
                  state_d  = IDLE;
                  tmo_inc  = 1'b1;
                  ptr_adv  = 1'b1;
                  wait_clr = 1'b1;
               end else begin
                  wait_inc = 1'b1;
               end
            end else begin
               state_d  = PUSH;
               wait_clr = 1'b1;
            end
         end
         PUSH: state_d = POP;
         POP: begin
            state_d = IDLE;
            ptr_adv = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         rr_ptr    <= 2'd0;
         wait_cnt  <= '0;
         trn       <= 2'd0;
         data_in_i <= '0;
         push_i    <= 1'b0;
         pop_i     <= 1'b0;
         busy      <= 1'b0;
         drop_cnt  <= 16'd0;
         tmo_cnt   <= 16'd0;
      end else begin
         state_q <= state_d;
         // strobes are decoded from the next state so they line up with it
         push_i  <= (state_d == PUSH);
         pop_i   <= (state_d == POP);
         busy    <= (state_d != IDLE);
         if (load) begin
            trn       <= pick_idx;
            data_in_i <= data_out_i[pick_idx];
         end
         if (ptr_adv)
            rr_ptr <= trn + 2'd1;
         if (wait_clr)
            wait_cnt <= '0;
         else if (wait_inc)
            wait_cnt <= wait_cnt + 1'b1;
         if (drop_inc && drop_cnt != CNT_MAX)
            drop_cnt <= drop_cnt + 16'd1;
         if (tmo_inc && tmo_cnt != CNT_MAX)
            tmo_cnt <= tmo_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_router_sched.sv
module tb_router_sched;
   import mesh_pkg::*;

   localparam int PW = 40;

   logic                clk;
   logic                rst;
   logic [3:0]          pndng_i;
   logic [3:0][PW-1:0]  data_out_i;
   logic [3:0]          full_o;
   logic [1:0]          trn;
   logic                push_i;
   logic [PW-1:0]       data_in_i;
   logic                pop_i;
   logic                busy;
   logic [15:0]         drop_cnt;
   logic [15:0]         tmo_cnt;

   typedef struct {
      logic [1:0]    src;
      logic [PW-1:0] pkt;
   } exp_t;

   exp_t sbq[$];
   int   push_cyc[$];
   int   cyc;
   int   n_vec;
   int   n_miss;

   router_sched #(.PCKG_SZ(PW), .N_TERM(4), .BLK_TIMEOUT(15)) dut (
      .clk        (clk),
      .rst        (rst),
      .pndng_i    (pndng_i),
      .data_out_i (data_out_i),
      .full_o     (full_o),
      .trn        (trn),
      .push_i     (push_i),
      .data_in_i  (data_in_i),
      .pop_i      (pop_i),
      .busy       (busy),
      .drop_cnt   (drop_cnt),
      .tmo_cnt    (tmo_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // scoreboard: every push must match the oldest expected transfer
   always @(negedge clk) begin
      if (rst) begin
         chk("push_pop_excl", {63'd0, push_i & pop_i}, 64'd0);
         if (push_i) begin
            push_cyc.push_back(cyc);
            chk("push_dest_valid", {63'd0, dest_of(data_in_i) < 8'd4}, 64'd1);
            if (sbq.size() == 0) begin
               chk("unexpected_push", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("push_trn", {62'd0, trn}, {62'd0, e.src});
               chk("push_data", {24'd0, data_in_i}, {24'd0, e.pkt});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      pndng_i = '0;
      full_o = '0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic wait_pop(input int max);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!pop_i && n < max);
      chk("pop_wait", {63'd0, pop_i}, 64'd1);
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      while (busy && n < max) begin
         tick();
         n++;
      end
      chk("idle_wait", {63'd0, busy}, 64'd0);
   endtask

   function automatic logic [PW-1:0] mk(input logic [7:0] id);
      return {id, 32'($urandom())};
   endfunction

   initial begin
      logic [PW-1:0] p, pa, pb;
      int            order [5];
      int            guard;
      order = '{0, 1, 2, 3, 0};
      n_vec = 0;
      n_miss = 0;
      cyc = 0;
      rst = 1'b0;
      pndng_i = '0;
      full_o = '0;
      data_out_i = '0;

      // reset state
      tick();
      chk("rst_trn", {62'd0, trn}, 64'd0);
      chk("rst_push", {63'd0, push_i}, 64'd0);
      chk("rst_pop", {63'd0, pop_i}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_data", {24'd0, data_in_i}, 64'd0);
      chk("rst_drop", {48'd0, drop_cnt}, 64'd0);
      chk("rst_tmo", {48'd0, tmo_cnt}, 64'd0);
      rst = 1'b1;
      tick();
      chk("idle_busy", {63'd0, busy}, 64'd0);

      // single request from terminal 2 to id 1
      p = mk(8'd1);
      data_out_i[2] = p;
      pndng_i = 4'b0100;
      sbq.push_back('{2'd2, p});
      tick();
      chk("s1_trn", {62'd0, trn}, 64'd2);
      chk("s1_busy", {63'd0, busy}, 64'd1);
      chk("s1_data", {24'd0, data_in_i}, {24'd0, p});
      tick();
      chk("s1_push", {63'd0, push_i}, 64'd1);
      chk("s1_nopop", {63'd0, pop_i}, 64'd0);
      tick();
      chk("s1_pop", {63'd0, pop_i}, 64'd1);
      chk("s1_pushoff", {63'd0, push_i}, 64'd0);
      chk("s1_trn_hold", {62'd0, trn}, 64'd2);
      pndng_i = '0;
      tick();
      chk("s1_idle", {63'd0, busy}, 64'd0);
      chk("s1_popoff", {63'd0, pop_i}, 64'd0);
      chk("s1_rr_ptr", {62'd0, dut.rr_ptr}, 64'd3);

      // all four pending, never cleared
      do_reset();
      for (int k = 0; k < 4; k++) data_out_i[k] = mk(8'(3 - k));
      push_cyc.delete();
      for (int i = 0; i < 5; i++) sbq.push_back('{2'(order[i]), data_out_i[order[i]]});
      pndng_i = 4'hF;
      guard = 0;
      while (push_cyc.size() < 5 && guard < 40) begin
         tick();
         guard++;
      end
      pndng_i = '0;
      chk("rr_push_count", 64'(push_cyc.size()), 64'd5);
      if (push_cyc.size() >= 5)
         for (int i = 1; i < 5; i++)
            chk("rr_gap", 64'(push_cyc[i] - push_cyc[i-1]), 64'd4);
      wait_idle(10);

      // blocked head on terminal 1, terminal 2 served afterwards
      do_reset();
      pa = mk(8'd3);
      pb = mk(8'd0);
      data_out_i[1] = pa;
      data_out_i[2] = pb;
      full_o = 4'b1000;
      pndng_i = 4'b0110;
      sbq.push_back('{2'd2, pb});
      tick();
      chk("blk_trn", {62'd0, trn}, 64'd1);
      repeat (14) tick();
      chk("blk_still_busy", {63'd0, busy}, 64'd1);
      chk("blk_tmo_before", {48'd0, tmo_cnt}, 64'd0);
      tick();
      chk("blk_idle", {63'd0, busy}, 64'd0);
      chk("blk_tmo", {48'd0, tmo_cnt}, 64'd1);
      chk("blk_rr_ptr", {62'd0, dut.rr_ptr}, 64'd2);
      tick();
      chk("blk_next_trn", {62'd0, trn}, 64'd2);
      tick();
      chk("blk_next_push", {63'd0, push_i}, 64'd1);
      tick();
      chk("blk_next_pop", {63'd0, pop_i}, 64'd1);
      pndng_i = '0;
      full_o = '0;
      tick();
      chk("blk_done", {63'd0, busy}, 64'd0);

      // invalid destination ids, 8'h07 and the first out-of-range id 4
      do_reset();
      data_out_i[0] = mk(8'h07);
      pndng_i = 4'b0001;
      tick();
      chk("drop_busy", {63'd0, busy}, 64'd1);
      tick();
      chk("drop_pop", {63'd0, pop_i}, 64'd1);
      chk("drop_nopush", {63'd0, push_i}, 64'd0);
      chk("drop_cnt1", {48'd0, drop_cnt}, 64'd1);
      pndng_i = '0;
      tick();
      chk("drop_idle", {63'd0, busy}, 64'd0);
      data_out_i[3] = mk(8'd4);
      pndng_i = 4'b1000;
      tick();
      tick();
      chk("drop4_pop", {63'd0, pop_i}, 64'd1);
      chk("drop_cnt2", {48'd0, drop_cnt}, 64'd2);
      pndng_i = '0;
      tick();

      // source withdraws while in CHECK
      do_reset();
      data_out_i[0] = mk(8'd2);
      pndng_i = 4'b0001;
      tick();
      chk("wd_busy", {63'd0, busy}, 64'd1);
      chk("wd_trn", {62'd0, trn}, 64'd0);
      pndng_i = '0;
      tick();
      chk("wd_idle", {63'd0, busy}, 64'd0);
      chk("wd_nopush", {63'd0, push_i}, 64'd0);
      chk("wd_nopop", {63'd0, pop_i}, 64'd0);
      chk("wd_rr_ptr", {62'd0, dut.rr_ptr}, 64'd0);

      // serve terminal 1 so rr_ptr moves to 2, then reset during a push
      pa = mk(8'd3);
      data_out_i[1] = pa;
      pndng_i = 4'b0010;
      sbq.push_back('{2'd1, pa});
      wait_pop(10);
      pndng_i = '0;
      wait_idle(10);
      chk("pre_rst_ptr", {62'd0, dut.rr_ptr}, 64'd2);
      data_out_i[2] = mk(8'd0);
      pndng_i = 4'b0100;
      tick();
      tick();
      chk("mid_push", {63'd0, push_i}, 64'd1);
      #1 rst = 1'b0;
      #1;
      chk("ar_push", {63'd0, push_i}, 64'd0);
      chk("ar_pop", {63'd0, pop_i}, 64'd0);
      chk("ar_busy", {63'd0, busy}, 64'd0);
      chk("ar_trn", {62'd0, trn}, 64'd0);
      chk("ar_data", {24'd0, data_in_i}, 64'd0);
      chk("ar_drop", {48'd0, drop_cnt}, 64'd0);
      chk("ar_tmo", {48'd0, tmo_cnt}, 64'd0);
      data_out_i[1] = mk(8'd1);
      data_out_i[3] = mk(8'd2);
      pndng_i = 4'b1010;
      sbq.push_back('{2'd1, data_out_i[1]});
      rst = 1'b1;
      wait_pop(10);
      pndng_i = '0;
      wait_idle(10);

      chk("sb_empty", 64'(sbq.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/router_sched.md
# router_sched

Registered round-robin scheduler for one mesh router. It shares the router's single internal transfer path among the four terminal interfaces and sequences each packet through a check, push and pop cycle. It applies output-FIFO backpressure, drops packets with an invalid destination, and abandons a blocked head after a timeout. It sits between the four per-terminal interface blocks and the internal push/pop bus of the router.

## Interface
- PCKG_SZ, 40, packet width in bits; bits [PCKG_SZ-1:PCKG_SZ-8] hold the decoded output-terminal id
- N_TERM, 4, number of terminals; the hardware is sized for 4, with a 2-bit index
- BLK_TIMEOUT, 15, cycles a head packet may wait on a full destination before being skipped
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-low
- pndng_i  in  [4]  terminal i has a decoded packet at its head
- data_out_i  in  [4][PCKG_SZ]  head packet of terminal i, with the routed id in the top byte
- full_o  in  [4]  output FIFO of terminal i cannot accept a push
- trn  out  2  index of the source terminal currently granted
- push_i  out  1  one-cycle strobe: data_in_i is written to the output FIFO whose id matches the top byte
- data_in_i  out  PCKG_SZ  latched packet being transferred
- pop_i  out  1  one-cycle strobe: the head of terminal trn is removed
- busy  out  1  high whenever state != IDLE
- drop_cnt  out  16  count of packets dropped for an invalid id; saturates at 16'hFFFF
- tmo_cnt  out  16  count of timeouts; saturates at 16'hFFFF

## Operation
- Reset (rst=0): all outputs are 0, state=IDLE, rr_ptr=0, wait_cnt=0.
- **IDLE**
  - rr_pick searches pndng_i starting at rr_ptr and wrapping 3→0.
  - On a hit k: trn<=k, data_in_i<=data_out_i[k], then go to CHECK.
  - With no pending terminal, stay in IDLE.
- **CHECK**: with dest = data_in_i[PCKG_SZ-1 -: 8]:
  - If pndng_i[trn]=0 (source withdrew): go to IDLE with no strobes; rr_ptr is unchanged.
  - Else if dest >= N_TERM: go to POP, increment drop_cnt, never assert push_i.
  - Else if full_o[dest]=1: stay in CHECK and increment wait_cnt.
    - When wait_cnt reaches BLK_TIMEOUT-1: go to IDLE, increment tmo_cnt, set rr_ptr<=trn+1, clear wait_cnt.
    - There is no pop on timeout; the packet stays at the source head.
  - Else: go to PUSH and clear wait_cnt.
- **PUSH**: push_i=1 for exactly one cycle, then go to POP.
- **POP**: pop_i=1 for exactly one cycle with trn held, then rr_ptr<=trn+1 (mod 4), then go to IDLE.
- trn and data_in_i hold steady from the IDLE→CHECK edge until the scheduler returns to IDLE.
- push_i and pop_i are never high in the same cycle. At most one push occurs per grant.
- Counter width rule: wait_cnt is $clog2(BLK_TIMEOUT+1) bits wide. drop_cnt and tmo_cnt hold at 16'hFFFF.
- Simultaneous requests: the first set bit at or after rr_ptr wins. Newly asserted pndng_i is ignored outside IDLE.
- full_o is sampled only in CHECK. A full flag that rises during PUSH does not cancel the push; the destination FIFO must reserve one slot.
- Reset mid-operation: an in-flight strobe drops immediately and no partial transfer is retried. After reset the scheduler restarts from IDLE with rr_ptr=0.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Unblocked packet:
  - pndng seen in IDLE at edge n.
  - push_i high during cycle n+2.
  - pop_i high during cycle n+3.
  - IDLE again at n+4.
- Throughput: 4 cycles per packet with a back-to-back source.
- Invalid-id drop: pop_i is high in cycle n+2 and the scheduler is IDLE at n+3.
- Blocked head: the timeout fires BLK_TIMEOUT cycles after entering CHECK, and the scheduler is IDLE on the next edge.

## Structure
- Shared package mesh_pkg holds:
  - PCKG_SZ default
  - ID_W=8
  - the function dest_of(pkt)
  - typedef enum logic [1:0] {IDLE, CHECK, PUSH, POP} sched_state_t
- One combinational sub-module, rr_pick: inputs req[4] and ptr[1:0]; outputs hit and idx[1:0] (rotating priority).
- The FSM, counters and output registers live in router_sched.

## Test plan
- Single request: pndng_i=4'b0100, id=1, full_o=0 → trn=2; push_i at cycle 2 with data_in_i equal to the packet; pop_i at cycle 3; rr_ptr=3.
- All four pending and never cleared → grant order 0,1,2,3,0 with exactly 4 cycles between pushes.
- Blocked head: src 1, id=3, full_o[3]=1 held → no push, tmo_cnt=1 after 15 CHECK cycles; then src 2 with a valid packet is served next.
- Invalid id: top byte=8'h07 → pop_i pulse, push_i stays 0, drop_cnt=1.
- Source withdraws: pndng_i[0] falls while in CHECK → IDLE with no strobes and rr_ptr=0.
- Async reset asserted during PUSH → push_i=0 without waiting for a clock edge; all outputs are 0; after release the first grant goes to the lowest pending index.
